// File: rtl/free_list_pkg.sv
// Shared sizing and types for the physical-register free list.
package free_list_pkg;

    localparam int PHYS_REG_SZ     = 64;
    // MSB index of a preg index, so an index is PHYS_REG_IDX_SZ+1 bits wide.
    localparam int PHYS_REG_IDX_SZ = $clog2(PHYS_REG_SZ) - 1;
    localparam int FL_PTR_SZ       = $clog2(PHYS_REG_SZ) + 1;

    typedef logic [PHYS_REG_IDX_SZ:0] PREG;
    typedef logic [FL_PTR_SZ-1:0]     FL_PTR;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of unallocated physical register indices.
// Dispatch pops from head, retire pushes the old dest at tail, and a
// retired-head pointer remembers how far allocations have committed so a
// mispredict can hand every speculative allocation back in one cycle.
//
// Handshake: alloc_valid is a pure function of registered state and never
// depends on alloc_req. An allocation is taken on a rising clk edge exactly
// when alloc_req && alloc_valid && !restore_enable; alloc_preg is the value
// consumed by that allocation. Dispatch must stall while alloc_valid is low.
module free_list
    import free_list_pkg::*;
#(
    parameter int PHYS_REGS = PHYS_REG_SZ,
    parameter int IDX_W     = PHYS_REG_IDX_SZ + 1,
    parameter int PTR_W     = $clog2(PHYS_REGS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [IDX_W-1:0] alloc_preg,
    input  logic             free_enable,
    input  logic [IDX_W-1:0] free_preg,
    input  logic             retire_enable,
    input  logic             restore_enable,
    output logic [PTR_W-1:0] free_count,
    output logic [PTR_W-1:0] arch_free_count
);

    logic [IDX_W-1:0] list [PHYS_REGS];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] ret_head;
    logic [PTR_W-1:0] tail;
    logic             alloc_fire;
    logic             free_fire;
    logic             dup_hit;

    // Occupancy and head value come straight from the pointers; no lookahead.
    always_comb begin
        free_count      = tail - head;
        arch_free_count = tail - ret_head;
        alloc_valid     = (free_count != '0);
        alloc_preg      = list[head[PTR_W-2:0]];
        alloc_fire      = alloc_req && alloc_valid && !restore_enable;
        // p0 is the architectural "never written" register and never re-enters the list.
        free_fire       = free_enable && (free_preg != '0);
    end

    // List storage: seeded with p1..p(N-1) at reset, written at tail on a free.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                if (i < PHYS_REGS - 1) begin
                    list[i] <= IDX_W'(i + 1);
                end else begin
                    list[i] <= '0;
                end
            end
        end else if (free_fire) begin
            list[tail[PTR_W-2:0]] <= free_preg;
        end
    end

    // Pointer updates; restore wins over a same-cycle allocation and folds in a same-cycle retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            ret_head <= '0;
            tail     <= PTR_W'(PHYS_REGS - 1);
        end else begin
            if (free_fire) begin
                tail <= tail + 1'b1;
            end
            if (retire_enable) begin
                ret_head <= ret_head + 1'b1;
            end
            if (restore_enable) begin
                head <= ret_head + PTR_W'(retire_enable);
            end else if (alloc_fire) begin
                head <= head + 1'b1;
            end
        end
    end

    // Is the preg being freed already sitting between head and tail?
    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < PHYS_REGS; i++) begin
            if ((((PTR_W'(i) - {1'b0, head[PTR_W-2:0]}) & PTR_W'(PHYS_REGS - 1)) < free_count)
                && (list[i] == free_preg)) begin
                dup_hit = 1'b1;
            end
        end
    end

    // Protocol misuse checks; these have no recovery path in hardware.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(free_fire && (free_count == PTR_W'(PHYS_REGS - 1))))
                else $error("free_list: free while list is full");
            assert (!(retire_enable && (ret_head == head)))
                else $error("free_list: retire with no outstanding allocation");
            assert (!(free_fire && dup_hit))
                else $error("free_list: preg %0d freed while already in list", free_preg);
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed and model-checked bench for free_list.
module tb_free_list;
    import free_list_pkg::*;

    localparam int N  = 64;
    localparam int IW = 6;
    localparam int PW = 7;

    logic          clk;
    logic          reset;
    logic          alloc_req;
    logic          alloc_valid;
    logic [IW-1:0] alloc_preg;
    logic          free_enable;
    logic [IW-1:0] free_preg;
    logic          retire_enable;
    logic          restore_enable;
    logic [PW-1:0] free_count;
    logic [PW-1:0] arch_free_count;

    int n_vec;
    int n_err;

    // Model: exp_q is the free list in FIFO order, alloc_q the allocated set.
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] alloc_q[$];
    int            pend;
    int            seen [N];

    free_list dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_valid     (alloc_valid),
        .alloc_preg      (alloc_preg),
        .free_enable     (free_enable),
        .free_preg       (free_preg),
        .retire_enable   (retire_enable),
        .restore_enable  (restore_enable),
        .free_count      (free_count),
        .arch_free_count (arch_free_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req      = 1'b0;
        free_enable    = 1'b0;
        free_preg      = '0;
        retire_enable  = 1'b0;
        restore_enable = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        idle();

        // Reset state
        do_reset();
        chk("rst_free_count", free_count, 63);
        chk("rst_arch_count", arch_free_count, 63);
        chk("rst_valid", alloc_valid, 1);
        chk("rst_preg", alloc_preg, 1);

        // Three back-to-back allocations
        for (int k = 0; k < 3; k++) begin
            alloc_req = 1'b1;
            chk("t1_preg", alloc_preg, k + 1);
            tick();
        end
        idle();
        chk("t1_free_count", free_count, 60);
        chk("t1_arch_count", arch_free_count, 63);
        chk("t1_next_preg", alloc_preg, 4);

        // Drain to empty, extra request, then a free refills
        do_reset();
        alloc_req = 1'b1;
        repeat (63) tick();
        chk("t2_empty_valid", alloc_valid, 0);
        chk("t2_empty_count", free_count, 0);
        tick();
        chk("t2_extra_valid", alloc_valid, 0);
        chk("t2_extra_count", free_count, 0);
        alloc_req   = 1'b0;
        free_enable = 1'b1;
        free_preg   = 6'd5;
        chk("t2_no_bypass", alloc_valid, 0);
        tick();
        idle();
        chk("t2_refill_valid", alloc_valid, 1);
        chk("t2_refill_preg", alloc_preg, 5);
        chk("t2_refill_count", free_count, 1);

        // Retire with p0 free, then restore
        do_reset();
        alloc_req = 1'b1;
        tick();
        tick();
        idle();
        retire_enable = 1'b1;
        free_enable   = 1'b1;
        free_preg     = '0;
        tick();
        idle();
        chk("t3_p0_dropped", free_count, 61);
        chk("t3_arch_count", arch_free_count, 62);
        restore_enable = 1'b1;
        tick();
        idle();
        chk("t3_restore_preg", alloc_preg, 2);
        chk("t3_restore_count", free_count, 62);
        chk("t3_restore_arch", arch_free_count, 62);

        // Four allocations, then retire + restore + ignored alloc in one cycle
        do_reset();
        alloc_req = 1'b1;
        repeat (4) tick();
        retire_enable  = 1'b1;
        restore_enable = 1'b1;
        tick();
        idle();
        chk("t4_preg", alloc_preg, 2);
        chk("t4_count", free_count, 62);
        chk("t4_arch", arch_free_count, 62);

        // Alloc + free together with a single entry left
        do_reset();
        alloc_req = 1'b1;
        repeat (62) tick();
        idle();
        chk("t5_count_one", free_count, 1);
        chk("t5_last_preg", alloc_preg, 63);
        alloc_req   = 1'b1;
        free_enable = 1'b1;
        free_preg   = 6'd40;
        tick();
        idle();
        chk("t5_count_held", free_count, 1);
        chk("t5_fifo_preg", alloc_preg, 40);
        alloc_req = 1'b1;
        tick();
        idle();
        chk("t5_final_valid", alloc_valid, 0);

        // Random alloc/free/retire with a model, wrapping the pointers
        do_reset();
        exp_q.delete();
        alloc_q.delete();
        pend = 0;
        for (int v = 1; v < N; v++) exp_q.push_back(IW'(v));
        for (int cyc = 0; cyc < 200; cyc++) begin
            logic          a;
            logic          f;
            logic          r;
            logic [IW-1:0] fp;
            int            idx;
            idle();
            a  = ($urandom_range(0, 99) < 55);
            f  = (alloc_q.size() > 0) && (exp_q.size() < N - 1) && ($urandom_range(0, 99) < 50);
            r  = (pend > 0) && ($urandom_range(0, 99) < 30);
            fp = '0;
            if (f) begin
                idx = $urandom_range(0, alloc_q.size() - 1);
                fp  = alloc_q[idx];
                alloc_q.delete(idx);
            end
            alloc_req     = a;
            retire_enable = r;
            if (f) begin
                free_enable = 1'b1;
                free_preg   = fp;
            end else if ($urandom_range(0, 99) < 5) begin
                free_enable = 1'b1;
                free_preg   = '0;
            end
            chk("rnd_valid", alloc_valid, (exp_q.size() != 0) ? 1 : 0);
            if (exp_q.size() != 0) chk("rnd_preg", alloc_preg, exp_q[0]);
            chk("rnd_count", free_count, exp_q.size());
            chk("rnd_arch", arch_free_count, exp_q.size() + pend);
            if (a && (exp_q.size() != 0)) begin
                alloc_q.push_back(exp_q.pop_front());
                pend++;
            end
            if (f) exp_q.push_back(fp);
            if (r) pend--;
            tick();
        end
        idle();

        // Drain the DUT and confirm every preg 1..63 exists exactly once
        for (int v = 0; v < N; v++) seen[v] = 0;
        for (int v = 0; v < alloc_q.size(); v++) seen[alloc_q[v]]++;
        for (int k = 0; k < 70 && alloc_valid; k++) begin
            alloc_req = 1'b1;
            if (exp_q.size() != 0) chk("drain_preg", alloc_preg, exp_q.pop_front());
            seen[alloc_preg]++;
            tick();
        end
        idle();
        chk("drain_done", alloc_valid, 0);
        chk("drain_model_empty", exp_q.size(), 0);
        chk("union_p0", seen[0], 0);
        for (int v = 1; v < N; v++) chk("union_preg", seen[v], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
